// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic initiator: accepts one command, runs one bus
// cycle with an ack timeout, then holds the response until the requester takes it.
module wb_host_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,

   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,

   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,

   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,

   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Counter value on the last BUS edge that may still see an ack.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

   state_t      state_reg;
   state_t      state_next;

   logic        we_reg;
   logic [31:0] adr_reg;
   logic [31:0] dat_reg;
   logic [3:0]  sel_reg;
   logic [15:0] wait_cnt_reg;
   logic [31:0] rsp_dat_reg;
   logic        rsp_err_reg;

   logic        load_cmd;
   logic        take_ack;
   logic        take_timeout;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      load_cmd     = 1'b0;
      take_ack     = 1'b0;
      take_timeout = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               load_cmd   = 1'b1;
               state_next = BUS;
            end
         end
         BUS: begin
            // An ack on the final wait edge still counts as a completion.
            if (wbm_ack_i) begin
               take_ack   = 1'b1;
               state_next = RESP;
            end else if (wait_cnt_reg == WAIT_LAST) begin
               take_timeout = 1'b1;
               state_next   = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         we_reg       <= 1'b0;
         adr_reg      <= 32'd0;
         dat_reg      <= 32'd0;
         sel_reg      <= 4'd0;
         wait_cnt_reg <= 16'd0;
      end else if (load_cmd) begin
         we_reg       <= cmd_we;
         adr_reg      <= cmd_adr;
         dat_reg      <= cmd_dat;
         sel_reg      <= cmd_sel;
         wait_cnt_reg <= 16'd0;
      end else if (state_reg == BUS && !wbm_ack_i) begin
         wait_cnt_reg <= wait_cnt_reg + 16'd1;
      end
   end

   // Response registers only move on a BUS completion, so late acks cannot disturb them.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         rsp_dat_reg <= 32'd0;
         rsp_err_reg <= 1'b0;
      end else if (take_ack) begin
         rsp_dat_reg <= we_reg ? 32'd0 : wbm_dat_i;
         rsp_err_reg <= 1'b0;
      end else if (take_timeout) begin
         rsp_dat_reg <= 32'd0;
         rsp_err_reg <= 1'b1;
      end
   end

   // Bus outputs are decoded from state so a reset drops the cycle without a clock edge.
   always_comb begin
      wbm_cyc_o = 1'b0;
      wbm_stb_o = 1'b0;
      wbm_we_o  = 1'b0;
      wbm_sel_o = 4'd0;
      wbm_adr_o = 32'd0;
      wbm_dat_o = 32'd0;
      if (state_reg == BUS) begin
         wbm_cyc_o = 1'b1;
         wbm_stb_o = 1'b1;
         wbm_we_o  = we_reg;
         wbm_sel_o = sel_reg;
         wbm_adr_o = adr_reg;
         wbm_dat_o = dat_reg;
      end
   end

   assign cmd_ready = (state_reg == IDLE);
   assign busy      = (state_reg != IDLE);
   assign rsp_valid = (state_reg == RESP);
   assign rsp_dat   = rsp_dat_reg;
   assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed and randomized transactions against a timing/response model of the initiator.
module tb_wb_host_master;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_adr = 32'd0;
   logic [31:0] cmd_dat = 32'd0;
   logic [3:0]  cmd_sel = 4'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [31:0] wbm_dat_i = 32'd0;
   logic        wbm_ack_i = 1'b0;
   logic        busy;

   int n_vec = 0;
   int n_bad = 0;

   wb_host_master #(.TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Idle-state view of every output: {busy,cmd_ready,rsp_valid,cyc,stb,we,sel,adr,dat}.
   function automatic logic [127:0] idle_view();
      return 128'({busy, cmd_ready, rsp_valid, wbm_cyc_o, wbm_stb_o, wbm_we_o,
                   wbm_sel_o, wbm_adr_o, wbm_dat_o});
   endfunction

   localparam logic [127:0] IDLE_EXP = 128'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                             4'd0, 32'd0, 32'd0});

   // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
   task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int ack_wait,
                          input logic [31:0] ack_dat, input int hold);
      logic        exp_err;
      logic [31:0] exp_dat;
      int          exp_cyc;
      int          ncyc;
      logic [31:0] got_dat;
      logic        got_err;

      // Reference: ack on wait index ack_wait completes only if it lands within TO bus cycles.
      exp_err = (ack_wait >= TO);
      exp_dat = (exp_err || we) ? 32'd0 : ack_dat;
      exp_cyc = exp_err ? TO : ack_wait + 1;

      check("cmd_ready_idle", 128'(cmd_ready), 128'(1'b1));
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_we    = ~we;
      cmd_adr   = $urandom;
      cmd_dat   = $urandom;
      cmd_sel   = 4'($urandom);

      ncyc = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!wbm_cyc_o) break;
         check("bus_signals", 128'({wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, busy}),
               128'({1'b1, we, sel, adr, dat, 1'b1}));
         wbm_ack_i = (ncyc == ack_wait);
         wbm_dat_i = wbm_ack_i ? ack_dat : $urandom;
         ncyc++;
      end
      wbm_ack_i = 1'b0;

      check("cyc_cycles", 128'(ncyc), 128'(exp_cyc));
      check("rsp_valid", 128'(rsp_valid), 128'(1'b1));
      check("rsp_dat", 128'(rsp_dat), 128'(exp_dat));
      check("rsp_err", 128'(rsp_err), 128'(exp_err));
      check("resp_bus_idle", 128'({cmd_ready, busy, wbm_stb_o, wbm_we_o, wbm_sel_o,
                                   wbm_adr_o, wbm_dat_o}), 128'({1'b0, 1'b1, 70'd0}));
      got_dat = rsp_dat;
      got_err = rsp_err;

      // Late ack plus a competing command while the response is held.
      if (hold > 0) begin
         wbm_ack_i = 1'b1;
         wbm_dat_i = ~exp_dat;
         cmd_valid = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("resp_hold", 128'({rsp_valid, cmd_ready, wbm_cyc_o, rsp_err, rsp_dat}),
               128'({1'b1, 1'b0, 1'b0, exp_err, exp_dat}));
      end
      wbm_ack_i = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("post_handshake", idle_view(), IDLE_EXP);
      $display("txn we=%0d adr=%08h sel=%0h ack_wait=%0d hold=%0d -> cyc=%0d dat=%08h err=%0d",
               we, adr, sel, ack_wait, hold, ncyc, got_dat, got_err);
   endtask

   initial begin
      logic        rw;
      logic [31:0] ra, rd, rk;
      logic [3:0]  rs;
      int          pick, aw;

      #2;
      rst_n = 1'b0;
      #1;
      check("reset_outputs", 128'({idle_view(), rsp_dat, rsp_err}), 128'({IDLE_EXP, 32'd0, 1'b0}));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("after_release", idle_view(), IDLE_EXP);

      // Minimum-latency read, delayed write, timeout with late ack, ack on the timeout edge.
      run_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 32'hDEAD_BEEF, 0);
      run_txn(1'b1, 32'h3000_0000, 32'h1234_5678, 4'h3, 3, 32'hCAFE_F00D, 1);
      run_txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1000, 32'h1111_2222, 3);
      run_txn(1'b0, 32'h3000_000C, 32'h0, 4'h1, TO - 1, 32'hA5A5_5A5A, 0);
      run_txn(1'b0, 32'h3000_0010, 32'h0, 4'hC, 1, 32'h0BAD_F00D, 20);
      run_txn(1'b1, 32'h3000_0014, 32'hFFFF_0000, 4'hF, TO, 32'h7777_7777, 2);

      // Reset in the middle of a bus cycle.
      cmd_valid = 1'b1;
      cmd_we    = 1'b0;
      cmd_adr   = 32'h4000_0000;
      cmd_sel   = 4'hF;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("cyc_before_reset", 128'({wbm_cyc_o, wbm_stb_o}), 128'(2'b11));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_mid_bus", idle_view(), IDLE_EXP);
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'h5555_AAAA;
      @(negedge clk);
      rst_n     = 1'b1;
      wbm_ack_i = 1'b0;
      @(negedge clk);
      check("after_mid_bus_reset", 128'({idle_view(), rsp_dat, rsp_err}),
            128'({IDLE_EXP, 32'd0, 1'b0}));
      $display("txn reset mid-bus adr=40000000 -> dropped");

      for (int n = 0; n < 30; n++) begin
         rw   = 1'($urandom_range(0, 1));
         ra   = $urandom;
         rd   = $urandom;
         rk   = $urandom;
         rs   = 4'($urandom);
         pick = $urandom_range(0, 9);
         if (pick < 6)       aw = pick % 4;
         else if (pick == 6) aw = TO - 2;
         else if (pick == 7) aw = TO - 1;
         else if (pick == 8) aw = TO;
         else                aw = TO + 12;
         run_txn(rw, ra, rd, rs, aw, rk, $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
